rf_wr_arbiter: RTL and testbench
================================

// Module: rf_wr_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage and a
//  long-latency unit (mul/div) that returns results out of pipeline order.
//  WB writes have priority. LL results wait in a small FIFO and drain on idle WB cycles.
//  A starvation counter forces a 1-cycle pipeline stall to drain the FIFO.
//  Also reports pending-LL destination hits to the hazard unit.
// PARAMETERS
//  DATA_W        32  register data width (= REG_DATA_WIDTH)
//  ADDR_W        5   register address width (= REG_ADDR_WIDTH)
//  DEPTH         2   LL result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  4   consecutive lost arbitrations before a forced drain (>=1)
// PORTS
//  clk           in   1       clock
//  rst_n         in   1       asynchronous active-low reset
//  pipe_wr_en    in   1       WB stage write request
//  pipe_wr_addr  in   ADDR_W  WB destination
//  pipe_wr_data  in   DATA_W  WB data
//  ll_valid      in   1       LL result valid
//  ll_ready      out  1       FIFO can accept (= !full, from registered state)
//  ll_addr       in   ADDR_W  LL destination
//  ll_data       in   DATA_W  LL result
//  pipe_stall    out  1       freeze IF..WB this cycle (forced drain)
//  q_addr1/2     in   ADDR_W  ID-stage source addresses
//  pend_hit1/2   out  1       q_addrN matches a valid FIFO entry (addr != 0)
//  rf_wr_en      out  1       register file write enable
//  rf_wr_addr    out  ADDR_W  register file write address
//  rf_wr_data    out  DATA_W  register file write data
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, rd/wr ptrs 0, starve_cnt 0, state NORM.
//    Reset values: rf_wr_en/addr/data = 0, ll_ready 0, pipe_stall 0, pend_hit* 0.
//    Reset mid-operation discards queued LL results.
//  - Enqueue: ll_valid && ll_ready at posedge. Entries with ll_addr==0 are accepted
//    and dropped, never stored. No bypass: a result is written no earlier than the
//    next cycle.
//  - FSM NORM: if pipe_wr_en and pipe_wr_addr!=0, grant WB.
//    Else, if FIFO is non-empty, grant FIFO head (pop at posedge).
//    Else rf_wr_en=0.
//  - FSM DRAIN: pipe_stall=1; pipe inputs ignored (upstream holds them).
//    Grant FIFO head, pop, then go to NORM next cycle.
//  - starve_cnt: +1 each cycle in NORM with FIFO non-empty and WB granted.
//    Cleared on any FIFO grant, or when the FIFO is empty.
//    At starve_cnt==STARVE_LIMIT-1 with increment, saturate and go NORM->DRAIN.
//    Cleared on entering DRAIN.
//  - Grant outputs are combinational from the selected source and current state
//    (0 latency for WB). rf_wr_en is never 1 with rf_wr_addr==0.
//  - Simultaneous pop+push when full: ll_ready was 0 that cycle, so no push occurs.
//    Pop+push when not full: both occur and count is unchanged.
//  - pend_hit: combinational compare over valid entries. Hazard unit stalls ID on hit.
//    This guarantees no WB write to an address with a pending LL write (WAW/RAW safe).
//  - Pointers wrap modulo DEPTH. Count is DEPTH+1 states with separate full/empty.
// TESTING
//  1 Reset held, random inputs -> rf_wr_en=0, ll_ready=0, pipe_stall=0.
//    Release: ll_ready=1.
//  2 pipe_wr_en=1 addr 5 data 0xA5A5A5A5, FIFO empty -> same-cycle rf_wr 5/0xA5A5A5A5.
//    addr 0 -> rf_wr_en=0.
//  3 ll_valid addr 7 data 0x1234, WB idle -> rf_wr 7/0x1234 one cycle later.
//    pend_hit1=1 for q_addr1=7 only while queued.
//  4 Two LL pushes (DEPTH=2), WB busy -> ll_ready=0. Third push held until first pop.
//    Drain order is FIFO.
//  5 FIFO holds 1 entry, WB writes every cycle -> after 4 lost cycles, pipe_stall=1
//    for exactly 1 cycle and the LL entry is written. WB data is written the
//    following cycle.
//  6 rst_n pulsed low with 2 entries queued -> FIFO empty, no stale rf_wr after release.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register-file write port between the in-order WB
// stage and a long-latency (mul/div) result FIFO. WB has priority. Queued LL
// results drain on idle WB cycles, or through a one-cycle forced pipeline stall
// once they have lost arbitration STARVE_LIMIT times in a row. The module also
// flags ID-stage source addresses that match a queued LL destination.
module rf_wr_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_wr_en,
    input  logic [ADDR_W-1:0] pipe_wr_addr,
    input  logic [DATA_W-1:0] pipe_wr_data,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic [DATA_W-1:0] ll_data,
    output logic              pipe_stall,
    input  logic [ADDR_W-1:0] q_addr1,
    input  logic [ADDR_W-1:0] q_addr2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        NORM  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve_cnt;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];

    logic              empty;
    logic              full;
    logic              wb_req;
    logic              grant_wb;
    logic              grant_ll;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  slot_vld;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    // Gated with rst_n so every output reads 0 while reset is held.
    assign ll_ready   = rst_n && !full;
    assign pipe_stall = rst_n && (state == DRAIN);

    // Writes to r0 are architecturally void, so a WB request to r0 leaves
    // the port free for the FIFO.
    assign wb_req = pipe_wr_en && (pipe_wr_addr != '0);

    // Accepted LL results for r0 are consumed here and never stored.
    assign push = ll_valid && ll_ready && (ll_addr != '0);
    assign pop  = grant_ll;

    // Select the write-port owner: FIFO during a forced drain, else WB first.
    always_comb begin
        grant_wb = 1'b0;
        grant_ll = 1'b0;
        if (rst_n) begin
            if (state == DRAIN) begin
                grant_ll = !empty;
            end else if (wb_req) begin
                grant_wb = 1'b1;
            end else begin
                grant_ll = !empty;
            end
        end
    end

    // Drive the register-file port from the granted source; idle port reads 0.
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        if (grant_wb) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = pipe_wr_addr;
            rf_wr_data = pipe_wr_data;
        end else if (grant_ll) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = fifo_addr[rd_ptr];
            rf_wr_data = fifo_data[rd_ptr];
        end
    end

    // Mark occupied slots: slot i is live when its distance from rd_ptr is below count.
    always_comb begin
        logic [PTR_W-1:0] off;
        slot_vld = '0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off         = PTR_W'(i) - rd_ptr;
            slot_vld[i] = (CNT_W'(off) < count);
        end
    end

    // Report ID-stage sources that still have an LL write outstanding.
    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_vld[i] && (q_addr1 != '0) && (fifo_addr[i] == q_addr1)) pend_hit1 = 1'b1;
                if (slot_vld[i] && (q_addr2 != '0) && (fifo_addr[i] == q_addr2)) pend_hit2 = 1'b1;
            end
        end
    end

    // Store LL payloads; storage needs no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ll_addr;
            fifo_data[wr_ptr] <= ll_data;
        end
    end

    // Advance FIFO pointers and occupancy; push and pop together keep count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Starvation FSM: count WB wins over a waiting FIFO and force a one-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORM;
            starve_cnt <= '0;
        end else begin
            case (state)
                NORM: begin
                    if (grant_wb && !empty) begin
                        if (starve_cnt == STV_W'(STARVE_LIMIT - 1)) begin
                            state      <= DRAIN;
                            starve_cnt <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + STV_W'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                DRAIN: begin
                    state      <= NORM;
                    starve_cnt <= '0;
                end
                default: begin
                    state      <= NORM;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed scenarios with literal expectations plus a
// long randomized run compared every cycle against a queue-based model.
module tb_rf_wr_arbiter;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pipe_wr_en;
    logic [ADDR_W-1:0] pipe_wr_addr;
    logic [DATA_W-1:0] pipe_wr_data;
    logic              ll_valid;
    logic              ll_ready;
    logic [ADDR_W-1:0] ll_addr;
    logic [DATA_W-1:0] ll_data;
    logic              pipe_stall;
    logic [ADDR_W-1:0] q_addr1;
    logic [ADDR_W-1:0] q_addr2;
    logic              pend_hit1;
    logic              pend_hit2;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;

    int checks = 0;
    int passes = 0;

    rf_wr_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
        .pipe_stall(pipe_stall),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_forced = 0;  // next cycle is a forced drain
    int   m_losses = 0;  // consecutive cycles the FIFO head lost to WB

    // 0 = port idle, 1 = WB owns the port, 2 = FIFO head owns the port
    function automatic int m_owner();
        if (!rst_n) return 0;
        if (m_forced) return (mq.size() > 0) ? 2 : 0;
        if (pipe_wr_en && pipe_wr_addr != 0) return 1;
        return (mq.size() > 0) ? 2 : 0;
    endfunction

    function automatic bit m_hit(input logic [ADDR_W-1:0] q);
        if (!rst_n || q == 0) return 0;
        foreach (mq[i]) if (mq[i].a == q) return 1;
        return 0;
    endfunction

    // Model state advances on each rising edge from the inputs seen that cycle.
    always @(posedge clk) begin
        int  own;
        bit  was_full;
        if (!rst_n) begin
            mq.delete();
            m_forced = 0;
            m_losses = 0;
        end else begin
            own      = m_owner();
            was_full = (mq.size() == DEPTH);
            if (m_forced) begin
                m_forced = 0;
                m_losses = 0;
            end else if (own == 1 && mq.size() > 0) begin
                m_losses++;
                if (m_losses == STARVE_LIMIT) begin
                    m_forced = 1;
                    m_losses = 0;
                end
            end else begin
                m_losses = 0;
            end
            if (own == 2) void'(mq.pop_front());
            if (ll_valid && !was_full && ll_addr != 0) mq.push_back({ll_addr, ll_data});
        end
    end

    // Every cycle, compare all DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        logic [41:0] act;
        logic [41:0] exp;
        int          own;
        logic        e_en;
        logic [ADDR_W-1:0] e_a;
        logic [DATA_W-1:0] e_d;
        own  = m_owner();
        e_en = (own != 0);
        e_a  = (own == 1) ? pipe_wr_addr : (own == 2) ? mq[0].a : '0;
        e_d  = (own == 1) ? pipe_wr_data : (own == 2) ? mq[0].d : '0;
        exp  = {e_en, e_a, e_d,
                rst_n && (mq.size() < DEPTH), rst_n && m_forced,
                m_hit(q_addr1), m_hit(q_addr2)};
        act  = {rf_wr_en, rf_wr_addr, rf_wr_data, ll_ready, pipe_stall, pend_hit1, pend_hit2};
        checks++;
        if (act === exp) passes++;
        else $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act, exp);
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_wr_en = 0; pipe_wr_addr = 0; pipe_wr_data = 0;
        ll_valid = 0; ll_addr = 0; ll_data = 0;
        q_addr1 = 0; q_addr2 = 0;
    endtask

    task automatic rnd_inputs();
        pipe_wr_en   = ($urandom_range(0, 99) < 60);
        pipe_wr_addr = ADDR_W'($urandom_range(0, 7));
        pipe_wr_data = $urandom;
        ll_valid     = ($urandom_range(0, 99) < 40);
        ll_addr      = ADDR_W'($urandom_range(0, 7));
        ll_data      = $urandom;
        q_addr1      = ADDR_W'($urandom_range(0, 7));
        q_addr2      = ADDR_W'($urandom_range(0, 7));
    endtask

    initial begin
        rst_n = 0;
        idle();

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            next(); rnd_inputs(); #2;
            chk("rst_wr_en", rf_wr_en, 0);
            chk("rst_ready", ll_ready, 0);
            chk("rst_stall", pipe_stall, 0);
        end
        next(); rst_n = 1; idle(); #2;
        chk("rel_ready", ll_ready, 1);

        // WB same-cycle write, then r0 suppressed
        next(); pipe_wr_en = 1; pipe_wr_addr = 5; pipe_wr_data = 32'hA5A5A5A5; #2;
        chk("wb_en", rf_wr_en, 1);
        chk("wb_addr", rf_wr_addr, 5);
        chk("wb_data", rf_wr_data, 32'hA5A5A5A5);
        next(); pipe_wr_addr = 0; #2;
        chk("wb_r0_en", rf_wr_en, 0);

        // LL result: no bypass, written next cycle, pend_hit only while queued
        next(); idle(); ll_valid = 1; ll_addr = 7; ll_data = 32'h1234; q_addr1 = 7; #2;
        chk("ll_nobypass", rf_wr_en, 0);
        chk("ll_hit_pre", pend_hit1, 0);
        next(); ll_valid = 0; #2;
        chk("ll_en", rf_wr_en, 1);
        chk("ll_addr", rf_wr_addr, 7);
        chk("ll_data", rf_wr_data, 32'h1234);
        chk("ll_hit", pend_hit1, 1);
        next(); #2;
        chk("ll_hit_post", pend_hit1, 0);
        chk("ll_done_en", rf_wr_en, 0);

        // Fill FIFO while WB busy, third push held, FIFO drain order
        next(); idle(); pipe_wr_en = 1; pipe_wr_addr = 3; pipe_wr_data = 32'h33;
        ll_valid = 1; ll_addr = 8; ll_data = 32'h88; #2;
        chk("f_ready0", ll_ready, 1);
        next(); ll_addr = 9; ll_data = 32'h99; #2;
        chk("f_ready1", ll_ready, 1);
        next(); ll_addr = 10; ll_data = 32'hAA; #2;
        chk("f_full", ll_ready, 0);
        chk("f_wb_addr", rf_wr_addr, 3);
        next(); pipe_wr_en = 0; #2;
        chk("f_full_pop", ll_ready, 0);
        chk("f_pop0", rf_wr_addr, 8);
        next(); #2;
        chk("f_ready_again", ll_ready, 1);
        chk("f_pop1", rf_wr_addr, 9);
        next(); ll_valid = 0; #2;
        chk("f_pop2", rf_wr_addr, 10);
        chk("f_pop2_data", rf_wr_data, 32'hAA);
        next(); #2;
        chk("f_empty", rf_wr_en, 0);

        // Starvation: four lost cycles then exactly one stall cycle
        next(); idle(); pipe_wr_en = 1; pipe_wr_addr = 4; pipe_wr_data = 32'h40;
        ll_valid = 1; ll_addr = 12; ll_data = 32'hC; #2;
        chk("s_wb0", rf_wr_addr, 4);
        next(); ll_valid = 0;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            #2;
            chk("s_nostall", pipe_stall, 0);
            chk("s_wb", rf_wr_addr, 4);
            next();
        end
        #2;
        chk("s_stall", pipe_stall, 1);
        chk("s_ll_addr", rf_wr_addr, 12);
        chk("s_ll_data", rf_wr_data, 32'hC);
        next(); #2;
        chk("s_unstall", pipe_stall, 0);
        chk("s_wb_after", rf_wr_data, 32'h40);

        // Reset with two entries queued
        next(); idle(); pipe_wr_en = 1; pipe_wr_addr = 2; pipe_wr_data = 32'h2;
        ll_valid = 1; ll_addr = 13; ll_data = 32'hD;
        next(); ll_addr = 14; ll_data = 32'hE; #2;
        next(); ll_valid = 0; q_addr1 = 13; q_addr2 = 14; #2;
        chk("r_hit_before", pend_hit1, 1);
        rst_n = 0; #1;
        chk("r_en_in_rst", rf_wr_en, 0);
        chk("r_hit_in_rst", pend_hit2, 0);
        next(); rst_n = 1; pipe_wr_en = 0; #2;
        chk("r_no_stale", rf_wr_en, 0);
        chk("r_hit1", pend_hit1, 0);
        chk("r_hit2", pend_hit2, 0);
        chk("r_ready", ll_ready, 1);

        // Randomized run with occasional resets
        for (int i = 0; i < 4000; i++) begin
            next();
            rnd_inputs();
            rst_n = ($urandom_range(0, 299) != 0);
        end
        next(); rst_n = 1; idle();
        repeat (4) next();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
